// File: rtl/pwm_peripheral_if.sv
// rtl/pwm_peripheral_if.sv - register-file to PWM output stage bundle
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  // Register file side: drives the control registers, observes the pins.
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    input  out, period_start
  );

  // Output stage side: consumes the registers, drives the pins.
  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-pin static/PWM output stage with double-buffered duty
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] r_prescaler;
  logic [7:0]    r_pwm_cnt;
  logic [7:0]    r_duty_sh;
  logic [15:0]   r_out;
  logic          r_period_start;

  logic          w_tick;
  logic          w_boundary;
  logic          w_pwm_raw;
  logic [15:0]   w_en_out;
  logic [15:0]   w_en_pwm;
  logic [15:0]   w_pwm_vec;

  assign w_tick     = (r_prescaler == PW'(CLK_DIV - 1));
  assign w_boundary = w_tick && (r_pwm_cnt == 8'hFF);

  // Full-scale duty is forced high so 0xFF gives a true 100% with no 1/256 gap.
  assign w_pwm_raw  = (r_duty_sh == 8'hFF) ? 1'b1 : (r_pwm_cnt < r_duty_sh);

  assign w_en_out   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign w_en_pwm   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign w_pwm_vec  = {16{w_pwm_raw}};

  // Prescaler: divides clk down to one PWM count step every CLK_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescaler <= '0;
    end else if (w_tick) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + PW'(1);
    end
  end

  // PWM counter and duty shadow: duty is only taken at the period wrap so a
  // mid-period write never produces a runt or stretched pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt      <= 8'h00;
      r_duty_sh      <= 8'h00;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'h01;
      end
      if (w_boundary) begin
        r_duty_sh <= bus.pwm_duty_cycle;
      end
    end
  end

  // Per-pin output mux: disabled -> 0, static -> 1, PWM -> shared waveform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= 16'h0000;
    end else begin
      r_out <= w_en_out & ((w_en_pwm & w_pwm_vec) | ~w_en_pwm);
    end
  end

  assign bus.out          = r_out;
  assign bus.period_start = r_period_start;

endmodule
